// File: rtl/alu_mul_seq.sv
// Iterative shift-and-add multiplier producing the low 32 bits of a RISC-V MUL.
// Borrows a dedicated ALU for its 32-bit add; one partial product per RUN cycle.
module alu_mul_seq #(
  parameter int unsigned EARLY_TERM = 1,
  parameter int unsigned CNT_W      = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_valid,
  output logic        start_ready,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        kill,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        busy,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_out
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 4;

  // ALUop encodings matching ALUop.vh (ALU_ADD / ALU_XXX)
  localparam logic [OP_W-1:0] ALU_ADD = 4'd0;
  localparam logic [OP_W-1:0] ALU_XXX = 4'd15;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [DATA_W-1:0] prod_q, prod_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_iter;

  // Finish when the counter wraps or no multiplier bits remain above bit 0
  always_comb begin
    last_iter = (cnt_q == CNT_LAST);
    if ((EARLY_TERM != 0) && (mplier_q[DATA_W-1:1] == '0)) begin
      last_iter = 1'b1;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state, datapath update and handshake/ALU outputs
  always_comb begin
    state_d     = state_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    prod_d      = prod_q;
    cnt_d       = cnt_q;
    start_ready = 1'b0;
    res_valid   = 1'b0;
    res_data    = '0;
    busy        = (state_q != ST_IDLE);
    alu_a       = '0;
    alu_b       = '0;
    alu_op      = ALU_XXX;

    unique case (state_q)
      ST_IDLE: begin
        start_ready = !kill;
        if (start_valid && !kill) begin
          mcand_d  = op_a;
          mplier_d = op_b;
          prod_d   = '0;
          cnt_d    = '0;
          state_d  = ST_RUN;
        end
      end

      ST_RUN: begin
        alu_a    = prod_q;
        alu_b    = mcand_q;
        alu_op   = ALU_ADD;
        if (mplier_q[0]) begin
          prod_d = alu_out;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_ONE;
        if (last_iter) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        res_valid = 1'b1;
        res_data  = prod_q;
        if (res_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A flush abandons the operation without touching the datapath registers
    if (kill) begin
      state_d  = ST_IDLE;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      prod_d   = prod_q;
      cnt_d    = cnt_q;
    end
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Scoreboard bench for alu_mul_seq: instance 0 uses early termination, instance 1 always runs 32 iterations.
module tb_alu_mul_seq;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_XXX = 4'd15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        kill = 1'b0;
  logic [1:0]  sv = '0;
  logic [1:0]  rr = '0;
  logic [1:0]  start_ready;
  logic [1:0]  res_valid;
  logic [1:0]  busy;
  logic [31:0] res_data [2];
  logic [31:0] alu_a [2];
  logic [31:0] alu_b [2];
  logic [3:0]  alu_op [2];
  logic [31:0] alu_out [2];

  always #5 clk = ~clk;

  // Reference ALU: only ADD is meaningful here; anything else yields a poison value
  assign alu_out[0] = (alu_op[0] == OP_ADD) ? alu_a[0] + alu_b[0] : 32'hDEADBEEF;
  assign alu_out[1] = (alu_op[1] == OP_ADD) ? alu_a[1] + alu_b[1] : 32'hDEADBEEF;

  alu_mul_seq #(.EARLY_TERM(1), .CNT_W(5)) u_dut_et (
    .clk(clk), .rst_n(rst_n), .start_valid(sv[0]), .start_ready(start_ready[0]),
    .op_a(op_a), .op_b(op_b), .kill(kill), .res_valid(res_valid[0]),
    .res_ready(rr[0]), .res_data(res_data[0]), .busy(busy[0]),
    .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_op(alu_op[0]), .alu_out(alu_out[0])
  );

  alu_mul_seq #(.EARLY_TERM(0), .CNT_W(5)) u_dut_full (
    .clk(clk), .rst_n(rst_n), .start_valid(sv[1]), .start_ready(start_ready[1]),
    .op_a(op_a), .op_b(op_b), .kill(kill), .res_valid(res_valid[1]),
    .res_ready(rr[1]), .res_data(res_data[1]), .busy(busy[1]),
    .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_op(alu_op[1]), .alu_out(alu_out[1])
  );

  typedef struct {
    logic [31:0] data;
    int          n;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int qsize(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  // Monitor: counts RUN cycles and latency, pops and compares on every result handshake
  int cyc = 0;
  int acc_cyc [2] = '{0, 0};
  int rc [2] = '{0, 0};
  int lat [2] = '{0, 0};
  bit seen [2] = '{1'b0, 1'b0};

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n || kill) begin
        rc[i]   = 0;
        seen[i] = 1'b0;
      end else begin
        if (sv[i] && start_ready[i]) acc_cyc[i] = cyc;
        if (busy[i] && alu_op[i] == OP_ADD) rc[i]++;
        if (res_valid[i] && !seen[i]) begin
          seen[i] = 1'b1;
          lat[i]  = cyc - acc_cyc[i];
        end
        if (!res_valid[i]) check("res_data_zero_when_idle", res_data[i], 32'h0);
        if (res_valid[i] && rr[i]) begin
          if (qsize(i) == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_result inst%0d: got %h expected no result", i, res_data[i]);
          end else begin
            if (i == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            check("res_data", res_data[i], e.data);
            check("run_cycles", 32'(rc[i]), 32'(e.n));
            check("latency", 32'(lat[i]), 32'(e.n + 1));
          end
          rc[i]   = 0;
          seen[i] = 1'b0;
        end
      end
    end
  end

  // Offer an operand pair; push the expectation once it is accepted
  task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int n, input bit expect_res);
    exp_t e;
    bit   acc;
    int   t;
    t    = 0;
    op_a = a;
    op_b = b;
    sv[i] = 1'b1;
    do begin
      acc = start_ready[i];
      @(posedge clk);
      #1;
      t++;
    end while (!acc && t < 50);
    sv[i] = 1'b0;
    if (!acc) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout inst%0d: got start_ready=0 expected 1", i);
    end else if (expect_res) begin
      e.data = exp;
      e.n    = n;
      if (i == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
  endtask

  task automatic drain(input int i);
    int t;
    t = 0;
    while (qsize(i) != 0 && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (qsize(i) != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL result_timeout inst%0d: got %0d pending expected 0", i, qsize(i));
      if (i == 0) q0.delete();
      else        q1.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw;
    int t;
    rr = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy[0]), 32'd0);
    check("reset_start_ready", 32'(start_ready[0]), 32'd1);
    check("reset_res_valid", 32'(res_valid[0]), 32'd0);
    check("reset_alu_op", 32'(alu_op[0]), 32'(OP_XXX));
    check("reset_res_data", res_data[0], 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed products
    issue(0, 32'd7, 32'd6, 32'd42, 3, 1'b1);                       drain(0);
    issue(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32, 1'b1);  drain(0);
    issue(1, 32'd3, 32'd2, 32'd6, 32, 1'b1);                       drain(1);
    issue(0, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1, 3, 1'b1);          drain(0);
    issue(0, 32'h00001234, 32'd0, 32'd0, 1, 1'b1);                 drain(0);

    // Backpressure: result held, new operands refused
    rr[0] = 1'b0;
    issue(0, 32'h00010001, 32'd3, 32'h00030003, 2, 1'b1);
    t = 0;
    while (!res_valid[0] && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    for (int k = 0; k < 10; k++) begin
      if (k == 3) begin
        op_a  = 32'd5;
        op_b  = 32'd5;
        sv[0] = 1'b1;
      end else begin
        sv[0] = 1'b0;
      end
      check("bp_res_valid", 32'(res_valid[0]), 32'd1);
      check("bp_res_data", res_data[0], 32'h00030003);
      check("bp_start_ready", 32'(start_ready[0]), 32'd0);
      @(posedge clk);
      #1;
    end
    sv[0] = 1'b0;
    rr[0] = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_busy", 32'(busy[0]), 32'd0);
    check("bp_release_start_ready", 32'(start_ready[0]), 32'd1);
    drain(0);

    // Kill in the second RUN cycle
    issue(0, 32'h00010000, 32'h00010000, 32'h0, 0, 1'b0);
    @(posedge clk);
    #1;
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    check("kill_busy", 32'(busy[0]), 32'd0);
    saw = 1'b0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (res_valid[0]) saw = 1'b1;
    end
    check("kill_no_result", 32'(saw), 32'd0);
    issue(0, 32'd9, 32'd9, 32'd81, 4, 1'b1);                       drain(0);

    // Asynchronous reset mid-RUN
    issue(0, 32'd9, 32'd9, 32'd0, 0, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy[0]), 32'd0);
    check("arst_alu_op", 32'(alu_op[0]), 32'(OP_XXX));
    check("arst_res_valid", 32'(res_valid[0]), 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (res_valid[0]) saw = 1'b1;
    end
    check("arst_no_result", 32'(saw), 32'd0);
    issue(0, 32'h0000FFFF, 32'h00010001, 32'hFFFFFFFF, 17, 1'b1);  drain(0);

    // kill together with start_valid in IDLE
    kill  = 1'b1;
    op_a  = 32'd2;
    op_b  = 32'd2;
    sv[0] = 1'b1;
    #1;
    check("kill_start_ready", 32'(start_ready[0]), 32'd0);
    @(posedge clk);
    #1;
    sv[0] = 1'b0;
    kill  = 1'b0;
    check("kill_start_busy", 32'(busy[0]), 32'd0);

    repeat (5) @(posedge clk);
    #1;
    check("queue0_empty", 32'(q0.size()), 32'd0);
    check("queue1_empty", 32'(q1.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
- Iterative shift-and-add sequencer that computes a RISC-V MUL (low 32 bits of the product) using one ALU instance.
- The ALU instance is dedicated to this block and used only for its 32-bit add.
- Sits beside the execute stage. The pipeline issues an operand pair over a valid/ready handshake and stalls until the result is returned over a second valid/ready handshake.
- The sequencer drives the ALU's A, B and ALUop inputs and samples its Out.

Parameters:
- EARLY_TERM, 1: 1 = stop iterating once the remaining multiplier bits are all zero; 0 = always run 32 iterations.
- CNT_W, 5: iteration counter width. Fixed at log2(32); do not override.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start_valid  in  1  operand pair valid
- start_ready  out  1  sequencer can accept an operand pair
- op_a  in  32  multiplicand (rs1)
- op_b  in  32  multiplier (rs2)
- kill  in  1  abort the current operation (pipeline flush)
- res_valid  out  1  result valid
- res_ready  in  1  consumer accepts result
- res_data  out  32  product[31:0]
- busy  out  1  high when the state is not IDLE
- alu_a  out  32  to ALU A
- alu_b  out  32  to ALU B
- alu_op  out  4  to ALU ALUop, encoded with the `ALUop.vh` macros
- alu_out  in  32  from ALU Out

Behaviour:
- Reset (rst_n low, asynchronous):
  - State = IDLE.
  - mcand, mplier, prod and cnt cleared to 0.
  - res_valid = 0, busy = 0, start_ready = 1.
  - Asserting rst_n mid-operation aborts it immediately; no result is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - start_ready = !kill.
  - On start_valid && start_ready: mcand <= op_a, mplier <= op_b, prod <= 0, cnt <= 0, go to RUN.
- RUN, one iteration per cycle:
  - alu_a = prod, alu_b = mcand, alu_op = `ALU_ADD`.
  - If mplier[0] = 1, prod <= alu_out; otherwise prod is held.
  - mcand <= mcand << 1 (bits shifted past bit 31 are discarded). mplier <= mplier >> 1 (logical). cnt <= cnt + 1.
  - Go to DONE when cnt == 31, or when EARLY_TERM = 1 and (mplier >> 1) == 0. Otherwise stay in RUN.
- RUN cycle count N:
  - EARLY_TERM = 1: N = max(1, index of the highest set bit of op_b + 1). op_b = 0 gives N = 1.
  - EARLY_TERM = 0: N = 32.
- DONE:
  - res_valid = 1, res_data = prod; both are held stable until the handshake completes.
  - On res_ready, go to IDLE.
  - start_ready = 0 in both RUN and DONE; start_valid is ignored.
- Latency: res_valid rises N+1 cycles after the accepting clock edge. The earliest next accept is the cycle after the res handshake, so there is no overlap.
- Outside RUN: alu_a = 0, alu_b = 0, alu_op = `ALU_XXX`.
  - All ALU-side outputs are combinational from state and registers.
  - res_data = 0 whenever res_valid = 0.
- Arithmetic: all values are modulo 2^32. Signed and unsigned operands give identical low-32-bit results, so no sign handling is needed.
- kill:
  - In any state, the next state is IDLE; registers are untouched, and a result pending in DONE is discarded.
  - kill has priority over start_valid: start_ready is deasserted while kill = 1, so nothing is accepted that cycle.
  - kill and res_ready in the same DONE cycle: kill wins and the handshake does not complete; the consumer drops the result.
- No X may propagate on res_data or alu_op after reset.

Test Plan:
- 7 x 6, EARLY_TERM = 1 → alu_op = `ALU_ADD` for exactly 3 RUN cycles; res_valid 4 cycles after accept; res_data = 42.
- 0xFFFFFFFF x 0xFFFFFFFF → 32 RUN cycles; res_data = 0x00000001. Repeat with EARLY_TERM = 0 and 3 x 2 → 32 cycles, result 6.
- 0xFFFFFFFD (-3) x 5 → res_data = 0xFFFFFFF1 after 3 RUN cycles. op_a = 0x1234, op_b = 0 → 1 RUN cycle, res_data = 0.
- Backpressure: hold res_ready low for 10 cycles after res_valid, pulse start_valid with new operands → res_valid and res_data stay stable, start_ready = 0, no new operation is accepted; res_ready high → IDLE next cycle.
- kill in the 2nd RUN cycle of 0x10000 x 0x10000 → IDLE next cycle, res_valid never asserts. A following 9 x 9 → 81.
- rst_n pulsed low mid-RUN (asynchronous, between edges) → busy = 0 and alu_op = `ALU_XXX` immediately. kill and start_valid asserted together in IDLE → start is not accepted.
